// File: rtl/flash_cmd_sequencer_pkg.sv
// Flash command sequencer shared definitions:
// CFI command words, op codes, status bits and FSM states.
package flash_cmd_sequencer_pkg;

   localparam int ADDR_W = 23;
   localparam int DATA_W = 16;

   localparam logic [DATA_W-1:0] CFI_READ_ARRAY   = 16'h00FF;
   localparam logic [DATA_W-1:0] CFI_READ_STATUS  = 16'h0070;
   localparam logic [DATA_W-1:0] CFI_PROGRAM      = 16'h0040;
   localparam logic [DATA_W-1:0] CFI_ERASE        = 16'h0020;
   localparam logic [DATA_W-1:0] CFI_CONFIRM      = 16'h00D0;
   localparam logic [DATA_W-1:0] CFI_UNLOCK       = 16'h0060;
   localparam logic [DATA_W-1:0] CFI_CLEAR_STATUS = 16'h0050;

   localparam logic [2:0] OP_READ        = 3'd0;
   localparam logic [2:0] OP_PROGRAM     = 3'd1;
   localparam logic [2:0] OP_ERASE       = 3'd2;
   localparam logic [2:0] OP_UNLOCK      = 3'd3;
   localparam logic [2:0] OP_READ_STATUS = 3'd4;

   localparam int SR_READY     = 7;
   localparam int SR_ERASE_ERR = 5;
   localparam int SR_PROG_ERR  = 4;
   localparam int SR_VPP_ERR   = 3;
   localparam int SR_LOCK_ERR  = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_POLL_CHK,
      S_EXIT_CHK,
      S_DONE
   } seq_state_e;

   function automatic logic op_reserved(input logic [2:0] op);
      return op > OP_READ_STATUS;
   endfunction

   function automatic logic status_err(input logic [DATA_W-1:0] s);
      return s[SR_ERASE_ERR] | s[SR_PROG_ERR] | s[SR_VPP_ERR] | s[SR_LOCK_ERR];
   endfunction

   // First bus write of every command sequence
   function automatic logic [DATA_W-1:0] setup_word(input logic [2:0] op);
      case (op)
         OP_PROGRAM:     return CFI_PROGRAM;
         OP_ERASE:       return CFI_ERASE;
         OP_UNLOCK:      return CFI_UNLOCK;
         OP_READ_STATUS: return CFI_READ_STATUS;
         default:        return CFI_READ_ARRAY;
      endcase
   endfunction

endpackage

// File: rtl/flash_cmd_sequencer_port.sv
// One controller access: req pulse, then wait for ready.
// Address/data/wren are held from the req cycle through ready.
module flash_port_access
   import flash_cmd_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              wren,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_req,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   logic              pending;
   logic              wren_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;

   assign busy  = pending;
   assign done  = pending & mem_ready;
   assign rdata = done ? mem_rdata : rdata_q;

   assign mem_req     = start;
   assign mem_address = start ? addr  : addr_q;
   assign mem_wdata   = start ? wdata : wdata_q;
   assign mem_wren    = start ? wren  : wren_q;

   // Latch access fields on start; track the outstanding access
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 1'b0;
         wren_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (start) begin
            pending <= 1'b1;
            wren_q  <= wren;
            addr_q  <= addr;
            wdata_q <= wdata;
         end else if (done) begin
            pending <= 1'b0;
         end
         if (done) rdata_q <= mem_rdata;
      end
   end

endmodule

// File: rtl/flash_cmd_sequencer.sv
// Turns one high-level flash command into its CFI bus-cycle
// sequence, with status polling, error clear and array-mode exit.
module flash_cmd_sequencer
   import flash_cmd_sequencer_pkg::*;
#(
   parameter int                POLL_W     = 25,
   parameter logic [POLL_W-1:0] POLL_LIMIT = 25'd25_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              cmd_ready,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              err,
   output logic              timeout,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_req,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   seq_state_e        state, state_d;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [1:0]        step;
   logic [POLL_W-1:0] poll_cnt;
   logic              array_mode;
   logic              clr_sent;
   logic              exit_ff;

   logic              accept, op_rd, poll_end;
   logic              acc_start, acc_wren, acc_busy, acc_done;
   logic [DATA_W-1:0] acc_wdata, acc_rdata;

   assign accept   = cmd_valid & cmd_ready;
   assign op_rd    = (op_q == OP_READ) | (op_q == OP_READ_STATUS);
   assign poll_end = result[SR_READY] | (poll_cnt == POLL_LIMIT);

   flash_port_access u_port (
      .clk         (clk),
      .rst         (rst),
      .start       (acc_start),
      .wren        (acc_wren),
      .addr        (addr_q),
      .wdata       (acc_wdata),
      .busy        (acc_busy),
      .done        (acc_done),
      .rdata       (acc_rdata),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_req     (mem_req),
      .mem_wren    (mem_wren),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_d;
   end

   // Next state: step 0/1 are command writes, 2 polls, 3 exits
   always_comb begin
      state_d = state;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (accept) state_d = op_reserved(cmd_op) ? S_DONE : S_ISSUE;
            else        state_d = S_IDLE;
         end
         S_ISSUE: if (!acc_busy) state_d = S_WAIT;
         S_WAIT: begin
            if (acc_done) begin
               unique case (step)
                  2'd0: state_d = S_ISSUE;
                  2'd1: state_d = op_rd ? S_DONE : S_ISSUE;
                  2'd2: state_d = S_POLL_CHK;
                  2'd3: state_d = exit_ff ? S_DONE : S_EXIT_CHK;
               endcase
            end
         end
         S_POLL_CHK: state_d = poll_end ? S_EXIT_CHK : S_ISSUE;
         S_EXIT_CHK: state_d = S_ISSUE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Outputs: handshake flags and the bus word for the current step
   always_comb begin
      cmd_ready = (state == S_IDLE) | (state == S_DONE);
      done      = (state == S_DONE);
      acc_start = (state == S_ISSUE) & ~acc_busy;
      acc_wren  = 1'b0;
      acc_wdata = '0;
      unique case (step)
         2'd0: begin
            acc_wren  = 1'b1;
            acc_wdata = setup_word(op_q);
         end
         2'd1: begin
            if (!op_rd) begin
               acc_wren  = 1'b1;
               acc_wdata = (op_q == OP_PROGRAM) ? data_q : CFI_CONFIRM;
            end
         end
         2'd2: acc_wren = 1'b0;
         2'd3: begin
            acc_wren  = 1'b1;
            acc_wdata = exit_ff ? CFI_READ_ARRAY : CFI_CLEAR_STATUS;
         end
      endcase
   end

   // Command context, step index, poll count and completion status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q       <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         step       <= '0;
         poll_cnt   <= '0;
         result     <= '0;
         err        <= 1'b0;
         timeout    <= 1'b0;
         array_mode <= 1'b0;
         clr_sent   <= 1'b0;
         exit_ff    <= 1'b0;
      end else if (accept) begin
         op_q     <= cmd_op;
         addr_q   <= cmd_addr;
         data_q   <= cmd_data;
         poll_cnt <= '0;
         result   <= '0;
         err      <= op_reserved(cmd_op);
         timeout  <= 1'b0;
         clr_sent <= 1'b0;
         exit_ff  <= 1'b0;
         step     <= (cmd_op == OP_READ && array_mode) ? 2'd1 : 2'd0;
         if (cmd_op != OP_READ && !op_reserved(cmd_op)) array_mode <= 1'b0;
      end else begin
         case (state)
            S_WAIT: begin
               if (acc_done) begin
                  if (!acc_wren) result <= acc_rdata;
                  case (step)
                     2'd0: step <= 2'd1;
                     2'd1: begin
                        if (op_rd) array_mode <= (op_q == OP_READ);
                        else       step <= 2'd2;
                     end
                     2'd2: if (poll_cnt != '1) poll_cnt <= poll_cnt + 1'b1;
                     2'd3: if (exit_ff) array_mode <= 1'b1;
                  endcase
               end
            end
            S_POLL_CHK: begin
               if (poll_end) begin
                  step    <= 2'd3;
                  timeout <= ~result[SR_READY];
                  err     <= status_err(result) | ~result[SR_READY];
               end
            end
            S_EXIT_CHK: begin
               if (status_err(result) && !clr_sent) begin
                  clr_sent <= 1'b1;
                  exit_ff  <= 1'b0;
               end else begin
                  exit_ff  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
